// File: rtl/uart_word_rx_if.sv
// rtl/uart_word_rx_if.sv - signal bundle between a UART word receiver and its user
//
// Purpose: groups the arm request, the UART line and the assembled-word outputs
//   of uart_word_rx so that one handle connects the block to its neighbour.
// Signals:
//   receive_in    arm request, level or one-cycle pulse   (master -> slave)
//   rx_in         asynchronous UART line, idles high      (master -> slave)
//   data_out      assembled word, WIDTH bits              (slave -> master)
//   new_data_out  one-cycle strobe, data_out is new       (slave -> master)
//   busy_out      word reception in progress              (slave -> master)
//   error_out     one-cycle framing-error strobe          (slave -> master)
// Modports: master (drives arm/line), slave (the receiver).

interface uart_word_rx_if #(
  parameter int WIDTH = 8
);
  logic             receive_in;
  logic             rx_in;
  logic [WIDTH-1:0] data_out;
  logic             new_data_out;
  logic             busy_out;
  logic             error_out;

  modport master (
    output receive_in,
    output rx_in,
    input  data_out,
    input  new_data_out,
    input  busy_out,
    input  error_out
  );

  modport slave (
    input  receive_in,
    input  rx_in,
    output data_out,
    output new_data_out,
    output busy_out,
    output error_out
  );
endinterface

// File: rtl/uart_word_rx.sv
// rtl/uart_word_rx.sv - UART 8N1 receiver assembling FRAMES bytes into one word
//
// Purpose: receives FRAMES consecutive UART frames (LSB first, one start bit,
//   FRAME_SIZE data bits, one stop bit) and presents them as one word, byte k
//   at data_out[FRAME_SIZE*k +: FRAME_SIZE]. Reception is enabled by an armed
//   flag set by receive_in and cleared when a word completes.
// Ports:
//   clk_in   system clock
//   rst_in   synchronous reset, active low
//   bus      uart_word_rx_if.slave: receive_in, rx_in, data_out,
//            new_data_out, busy_out, error_out
// Parameters: CLK_BAUD_RATIO (>= 4) clocks per bit, FRAME_SIZE data bits per
//   frame, FRAMES (>= 1) frames per word.
// Optional feature macro: UART_WORD_RX_FRAMING_CHECK_EN. When defined, a stop
//   bit sampled low discards the partial word and pulses error_out; when not
//   defined the stop bit is ignored and error_out stays 0.

module uart_word_rx #(
  parameter int CLK_BAUD_RATIO = 25,
  parameter int FRAME_SIZE     = 8,
  parameter int FRAMES         = 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  uart_word_rx_if.slave bus
);

  localparam int W    = FRAME_SIZE * FRAMES;
  localparam int BCW  = (CLK_BAUD_RATIO > 1) ? $clog2(CLK_BAUD_RATIO) : 1;
  localparam int BITW = $clog2(FRAME_SIZE + 1);
  localparam int FCW  = $clog2(FRAMES + 1);

  localparam logic [BCW-1:0]  HALF_M1  = BCW'(CLK_BAUD_RATIO / 2 - 1);
  localparam logic [BCW-1:0]  FULL_M1  = BCW'(CLK_BAUD_RATIO - 1);
  localparam logic [BITW-1:0] LAST_BIT = BITW'(FRAME_SIZE - 1);
  localparam logic [FCW-1:0]  LAST_FRM = FCW'(FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rxs_q;
  logic [BCW-1:0]        baud_q, baud_d;
  logic [BITW-1:0]       bit_q, bit_d;
  logic [FCW-1:0]        frame_q, frame_d;
  logic [FRAME_SIZE-1:0] shift_q, shift_d;
  logic [W-1:0]          shadow_q, shadow_d;
  logic [W-1:0]          data_q, data_d;
  logic                  new_data_q, new_data_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  armed_q, armed_d;
  logic                  accept;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      baud_q     <= '0;
      bit_q      <= '0;
      frame_q    <= '0;
      shift_q    <= '0;
      shadow_q   <= '0;
      data_q     <= '0;
      new_data_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= bus.rx_in;
      rxs_q      <= rx_meta_q;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      shift_q    <= shift_d;
      shadow_q   <= shadow_d;
      data_q     <= data_d;
      new_data_q <= new_data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    shift_d    = shift_q;
    shadow_d   = shadow_q;
    data_d     = data_q;
    new_data_d = 1'b0;
    busy_d     = busy_q;
    err_d      = 1'b0;
    armed_d    = armed_q | bus.receive_in;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (armed_q || bus.receive_in) state_d = S_WAIT_START;
      end

      S_WAIT_START: begin
        if (!rxs_q) begin
          state_d = S_START;
          baud_d  = '0;
          busy_d  = 1'b1;
        end
      end

      // Re-check the start bit near its middle; a high line means a glitch.
      S_START: begin
        if (baud_q == HALF_M1) begin
          baud_d = '0;
          bit_d  = '0;
          if (rxs_q) begin
            state_d = S_WAIT_START;
            busy_d  = (frame_q != '0);
          end else begin
            state_d = S_DATA;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d                = '0;
          shift_d               = shift_q >> 1;
          shift_d[FRAME_SIZE-1] = rxs_q;
          bit_d                 = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
      S_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d = '0;
`ifdef UART_WORD_RX_FRAMING_CHECK_EN
          if (!rxs_q) begin
            err_d    = 1'b1;
            shadow_d = '0;
            frame_d  = '0;
            busy_d   = 1'b0;
            state_d  = (armed_q || bus.receive_in) ? S_WAIT_START : S_IDLE;
          end else begin
            accept = 1'b1;
          end
`else
          accept = 1'b1;
`endif
          if (accept) begin
            shadow_d[int'(frame_q)*FRAME_SIZE +: FRAME_SIZE] = shift_q;
            if (frame_q == LAST_FRM) begin
              data_d     = shadow_d;
              new_data_d = 1'b1;
              busy_d     = 1'b0;
              frame_d    = '0;
              // The completing word consumes the arm unless receive_in renews it now.
              state_d    = bus.receive_in ? S_WAIT_START : S_IDLE;
            end else begin
              frame_d = frame_q + 1'b1;
              state_d = S_WAIT_START;
            end
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (new_data_d && !bus.receive_in) armed_d = 1'b0;
  end

  assign bus.data_out     = data_q;
  assign bus.new_data_out = new_data_q;
  assign bus.busy_out     = busy_q;
  assign bus.error_out    = err_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// tb/tb_uart_word_rx.sv - directed self-checking bench for uart_word_rx

module tb_uart_word_rx;

  localparam int R       = 25;
  localparam int LATENCY = 2 + R / 2 + 9 * R + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;

  int compared = 0;
  int mismatched = 0;

  uart_word_rx_if #(.WIDTH(8))  if1 ();
  uart_word_rx_if #(.WIDTH(16)) if2 ();
  uart_word_rx_if #(.WIDTH(24)) if3 ();
  uart_word_rx_if #(.WIDTH(64)) if8 ();

  assign if1.rx_in = rx;
  assign if2.rx_in = rx;
  assign if3.rx_in = rx;
  assign if8.rx_in = rx;

  uart_word_rx #(.CLK_BAUD_RATIO(R), .FRAME_SIZE(8), .FRAMES(1)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .bus(if1.slave));
  uart_word_rx #(.CLK_BAUD_RATIO(R), .FRAME_SIZE(8), .FRAMES(2)) dut2 (
    .clk_in(clk), .rst_in(rst_n), .bus(if2.slave));
  uart_word_rx #(.CLK_BAUD_RATIO(R), .FRAME_SIZE(8), .FRAMES(3)) dut3 (
    .clk_in(clk), .rst_in(rst_n), .bus(if3.slave));
  uart_word_rx #(.CLK_BAUD_RATIO(R), .FRAME_SIZE(8), .FRAMES(8)) dut8 (
    .clk_in(clk), .rst_in(rst_n), .bus(if8.slave));

  always #5 clk = ~clk;

  // Pulse monitor, sampled 2 time units after each rising edge.
  int   cyc = 0;
  int   nd[4] = '{default: 0};
  int   nd_cyc[4] = '{default: 0};
  int   errc[4] = '{default: 0};
  int   dbl = 0;
  logic [3:0] prev_nd = 4'b0;
  logic [3:0] vec_nd;
  logic [3:0] vec_err;
  logic busy_after3 = 1'b1;

  always @(posedge clk) begin
    cyc++;
    #2;
    vec_nd  = {if8.new_data_out, if3.new_data_out, if2.new_data_out, if1.new_data_out};
    vec_err = {if8.error_out, if3.error_out, if2.error_out, if1.error_out};
    if (prev_nd[2]) busy_after3 = if3.busy_out;
    for (int i = 0; i < 4; i++) begin
      if (vec_nd[i]) begin
        nd[i]++;
        nd_cyc[i] = cyc;
        if (prev_nd[i]) dbl++;
      end
      if (vec_err[i]) errc[i]++;
    end
    prev_nd = vec_nd;
  end

  int last_fall = 0;
  int n0 = 0;
  int e0 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    last_fall = cyc;
    tick(R);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(R);
    end
    rx = stop_bit;
    tick(R);
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    rx = 1'b1;
    if1.receive_in = 1'b0;
    if2.receive_in = 1'b0;
    if3.receive_in = 1'b0;
    if8.receive_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    reset_all();

    // Reset state
    check("rst_data3", if3.data_out, 64'h0);
    check("rst_nd3", if3.new_data_out, 64'h0);
    check("rst_busy3", if3.busy_out, 64'h0);
    check("rst_err3", if3.error_out, 64'h0);
    check("rst_data8", if8.data_out, 64'h0);

    // FRAMES=3, level arm, three back-to-back bytes
    if3.receive_in = 1'b1;
    tick(1);
    n0 = nd[2];
    send_byte(8'h12, 1'b1);
    check("t1_busy_between", if3.busy_out, 64'h1);
    check("t1_no_early_pulse", 64'(nd[2] - n0), 64'h0);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    tick(2);
    if3.receive_in = 1'b0;
    check("t1_pulses", 64'(nd[2] - n0), 64'h1);
    check("t1_data", if3.data_out, 64'h563412);
    check("t1_busy_after", busy_after3, 64'h0);
    check("t1_latency", 64'(nd_cyc[2] - last_fall), 64'(LATENCY));

    // FRAMES=8, single-cycle arm, then a second unarmed word
    reset_all();
    if8.receive_in = 1'b1;
    tick(1);
    if8.receive_in = 1'b0;
    n0 = nd[3];
    for (int k = 1; k <= 8; k++) send_byte(8'(k), 1'b1);
    tick(2);
    check("t2_pulses", 64'(nd[3] - n0), 64'h1);
    check("t2_data", if8.data_out, 64'h0807060504030201);
    for (int k = 8'h21; k <= 8'h28; k++) send_byte(8'(k), 1'b1);
    tick(2);
    check("t2_unarmed_pulses", 64'(nd[3] - n0), 64'h1);
    check("t2_unarmed_data", if8.data_out, 64'h0807060504030201);
    check("t2_unarmed_busy", if8.busy_out, 64'h0);

    // FRAMES=1, start-bit glitch then a valid byte
    reset_all();
    if1.receive_in = 1'b1;
    tick(1);
    if1.receive_in = 1'b0;
    n0 = nd[0];
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(2);
    check("t3_busy_in_glitch", if1.busy_out, 64'h1);
    tick(20);
    check("t3_busy_after_glitch", if1.busy_out, 64'h0);
    check("t3_no_pulse", 64'(nd[0] - n0), 64'h0);
    send_byte(8'hA5, 1'b1);
    tick(2);
    check("t3_pulses", 64'(nd[0] - n0), 64'h1);
    check("t3_data", if1.data_out, 64'hA5);
    check("t3_latency", 64'(nd_cyc[0] - last_fall), 64'(LATENCY));

    // FRAMES=2, reset in the middle of the second byte
    reset_all();
    if2.receive_in = 1'b1;
    tick(1);
    if2.receive_in = 1'b0;
    send_byte(8'hFF, 1'b1);
    rx = 1'b0;
    tick(100);
    rst_n = 1'b0;
    tick(1);
    check("t4_rst_data", if2.data_out, 64'h0);
    check("t4_rst_nd", if2.new_data_out, 64'h0);
    check("t4_rst_busy", if2.busy_out, 64'h0);
    check("t4_rst_err", if2.error_out, 64'h0);
    rst_n = 1'b1;
    rx = 1'b1;
    tick(30);
    if2.receive_in = 1'b1;
    tick(1);
    if2.receive_in = 1'b0;
    n0 = nd[1];
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(2);
    check("t4_pulses", 64'(nd[1] - n0), 64'h1);
    check("t4_data", if2.data_out, 64'h2211);

    // FRAMES=1, stop bit low
    reset_all();
    if1.receive_in = 1'b1;
    tick(1);
    if1.receive_in = 1'b0;
    n0 = nd[0];
    e0 = errc[0];
    send_byte(8'h3C, 1'b0);
    rx = 1'b1;
    tick(30);
`ifdef UART_WORD_RX_FRAMING_CHECK_EN
    check("t5_err_pulses", 64'(errc[0] - e0), 64'h1);
    check("t5_no_pulse", 64'(nd[0] - n0), 64'h0);
    check("t5_data_kept", if1.data_out, 64'h0);
`else
    check("t5_pulses", 64'(nd[0] - n0), 64'h1);
    check("t5_data", if1.data_out, 64'h3C);
    check("t5_no_err", 64'(errc[0] - e0), 64'h0);
`endif

    check("never_double_pulse", 64'(dbl), 64'h0);
    check("no_err_other", 64'(errc[1] + errc[2] + errc[3]), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
